// File: rtl/axicb_prio_arbiter.sv
// Round-robin arbiter with static priority layers and transfer locking.
// Optional AXICB_ARB_AGING_EN: long-waiting requesters are promoted above every level.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | grant follows req combinationally (priority, then round-robin)
// S_LOCKED | grant held on lock_id_q until the last beat is accepted
module axicb_prio_arbiter #(
   parameter int                         REQ_NB       = 4,
   parameter int                         PRIO_NB      = 4,
   parameter int                         PRIO_W       = (PRIO_NB > 1) ? $clog2(PRIO_NB) : 1,
   parameter logic [REQ_NB*PRIO_W-1:0]   REQ_PRIORITY = '0,
   parameter int                         AGE_MAX      = 16
) (
   input  logic                      aclk,
   input  logic                      srst,
   input  logic [REQ_NB-1:0]         req,
   input  logic                      en,
   input  logic                      last,
   output logic [REQ_NB-1:0]         grant,
   output logic [$clog2(REQ_NB)-1:0] grant_id,
   output logic                      busy
);

   localparam int ID_W = $clog2(REQ_NB);
`ifdef AXICB_ARB_AGING_EN
   localparam int NLVL  = PRIO_NB + 1;
   localparam int AGE_W = $clog2(AGE_MAX + 1);
`else
   localparam int NLVL  = PRIO_NB;
`endif
   localparam int LVL_W = (NLVL > 1) ? $clog2(NLVL) : 1;

   if (REQ_NB < 2 || REQ_NB > 16 || PRIO_NB < 1 || PRIO_NB > 8 || AGE_MAX < 1) begin : g_param_chk
      $error("axicb_prio_arbiter: illegal parameter set");
   end

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   lock_id_q, lock_id_d;
   logic [ID_W-1:0]   ptr_q [NLVL];
   logic [ID_W-1:0]   ptr_d [NLVL];

   logic [LVL_W-1:0]  lvl [REQ_NB];
   logic [LVL_W-1:0]  top_lvl;
   logic              any_req;
   logic [ID_W-1:0]   cur_ptr;
   logic              hit_hi, hit_any;
   logic [ID_W-1:0]   idx_hi, idx_any;
   logic [ID_W-1:0]   win_id;
   logic [ID_W-1:0]   nxt_ptr;

`ifdef AXICB_ARB_AGING_EN
   logic [AGE_W-1:0]  age_q [REQ_NB];
   logic [AGE_W-1:0]  age_d [REQ_NB];
`endif

   // Effective level per requester; aged requesters sit on the extra top level.
   always_comb begin
      int p;
      p       = 0;
      top_lvl = '0;
      any_req = 1'b0;
      for (int i = 0; i < REQ_NB; i++) begin
         p = int'(REQ_PRIORITY[i*PRIO_W +: PRIO_W]);
         if (p >= PRIO_NB) p = PRIO_NB - 1;
         lvl[i] = LVL_W'(p);
`ifdef AXICB_ARB_AGING_EN
         if (age_q[i] == AGE_W'(AGE_MAX)) lvl[i] = LVL_W'(PRIO_NB);
`endif
         if (req[i] && (!any_req || lvl[i] > top_lvl)) begin
            top_lvl = lvl[i];
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      cur_ptr = '0;
      for (int l = 0; l < NLVL; l++) begin
         if (LVL_W'(l) == top_lvl) cur_ptr = ptr_q[l];
      end
      hit_hi  = 1'b0;
      hit_any = 1'b0;
      idx_hi  = '0;
      idx_any = '0;
      for (int i = 0; i < REQ_NB; i++) begin
         if (req[i] && lvl[i] == top_lvl) begin
            if (!hit_any) begin
               hit_any = 1'b1;
               idx_any = ID_W'(i);
            end
            if (!hit_hi && ID_W'(i) >= cur_ptr) begin
               hit_hi = 1'b1;
               idx_hi = ID_W'(i);
            end
         end
      end
      // Nothing at or above the pointer: wrap to the lowest candidate.
      win_id  = hit_hi ? idx_hi : idx_any;
      nxt_ptr = (win_id == ID_W'(REQ_NB - 1)) ? '0 : win_id + ID_W'(1);
   end

   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      ptr_d     = ptr_q;
      grant     = '0;
      grant_id  = '0;
      busy      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               grant    = REQ_NB'(1) << win_id;
               grant_id = win_id;
               if (en) begin
                  for (int l = 0; l < NLVL; l++) begin
                     if (LVL_W'(l) == top_lvl) ptr_d[l] = nxt_ptr;
                  end
                  if (!last) begin
                     lock_id_d = win_id;
                     state_d   = S_LOCKED;
                  end
               end
            end
         end
         S_LOCKED: begin
            grant    = REQ_NB'(1) << lock_id_q;
            grant_id = lock_id_q;
            busy     = 1'b1;
            if (en && last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef AXICB_ARB_AGING_EN
   always_comb begin
      for (int i = 0; i < REQ_NB; i++) begin
         age_d[i] = age_q[i];
         if (!req[i] || (grant[i] && en))     age_d[i] = '0;
         else if (age_q[i] != AGE_W'(AGE_MAX)) age_d[i] = age_q[i] + AGE_W'(1);
      end
   end

   always_ff @(posedge aclk) begin
      if (srst) begin
         for (int i = 0; i < REQ_NB; i++) age_q[i] <= '0;
      end else begin
         age_q <= age_d;
      end
   end
`endif

   always_ff @(posedge aclk) begin
      if (srst) begin
         state_q   <= S_IDLE;
         lock_id_q <= '0;
         for (int l = 0; l < NLVL; l++) ptr_q[l] <= '0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         ptr_q     <= ptr_d;
      end
   end

endmodule

// File: doc/axicb_prio_arbiter.md
Name: axicb_prio_arbiter

Overview:
Parametrised round-robin arbiter with per-requester static priority levels and transfer locking.
Grants one requester at a time. Holds the grant across a multi-beat transfer until its last beat is accepted.
Used by the crossbar switch ports to arbitrate masters/slaves onto one channel.
Generalises the fixed 4/8-requester arbiter to any REQ_NB, with real priority layers and burst lock.

Parameters:
REQ_NB, 4, number of requesters; legal 2..16.
PRIO_NB, 4, number of priority levels; legal 1..8; higher value wins.
PRIO_W, $clog2(PRIO_NB) (min 1), width of one priority field.
REQ_PRIORITY, 0, packed REQ_NB*PRIO_W vector; field i is requester i's level; values >= PRIO_NB are clamped to PRIO_NB-1.
AGE_MAX, 16, wait cycles before a requester is promoted (optional feature only).

Ports:
aclk  in  1  clock
srst  in  1  reset; synchronous, active-high
req  in  REQ_NB  request vector
en  in  1  granted beat accepted this cycle (handshake fired)
last  in  1  qualifies en: final beat of the granted transfer
grant  out  REQ_NB  one-hot grant, or all zero
grant_id  out  $clog2(REQ_NB)  index of the granted bit; 0 when grant==0
busy  out  1  high while in LOCKED

Behaviour:
- Single clock domain on aclk. srst is synchronous and active-high, sampled on the aclk rising edge.
- srst effects: state -> IDLE, all level pointers -> 0, lock_id -> 0, age counters -> 0. srst dominates en in the same cycle. srst asserted while LOCKED drops the lock at the next edge.
- Two-state FSM: IDLE and LOCKED.
- IDLE grant, combinational from req, same-cycle (zero latency):
  - L = highest priority level among active requests.
  - Candidates = active requests at level L.
  - Grant the lowest candidate index >= ptr[L]; if none, the lowest candidate index (wrap).
  - req==0 -> grant=0, grant_id=0.
- IDLE, en & |grant:
  - ptr[L] <= (granted index + 1) mod REQ_NB; other levels' pointers unchanged.
  - last=1 -> stay IDLE.
  - last=0 -> lock_id <= granted index, go LOCKED.
- LOCKED:
  - grant = onehot(lock_id), independent of req (req drop is ignored).
  - busy=1.
  - Pointers frozen.
  - en & last -> IDLE at the next edge. The next grant is evaluated combinationally in the cycle after the exit; no bubble beyond that edge.
- en while grant==0 is ignored. last without en is ignored.
- Priority is not preemptive: a higher-level request arriving in LOCKED waits for the lock to end.
- Reset outputs: grant follows req in IDLE (0 if req==0), grant_id=0, busy=0.
- grant always has at most one bit set.

Optional Feature:
Macro AXICB_ARB_AGING_EN.
- Defined:
  - Each requester has an age counter of $clog2(AGE_MAX+1) bits.
  - The counter increments each cycle req[i]=1 and not (grant[i] & en); it saturates at AGE_MAX.
  - The counter clears when req[i]=0 or on its own handshake.
  - A requester at AGE_MAX is treated as level PRIO_NB (above all others).
  - Multiple aged requesters share a dedicated aged pointer with the same round-robin rule.
  - The aged pointer updates on handshake of an aged winner.
- Undefined: no counters, AGE_MAX unused, behaviour exactly as above.

Test Plan:
1. REQ_NB=4, all priorities 0, req=1111, en=1, last=1 every cycle -> grant 0001,0010,0100,1000,0001; busy=0 throughout.
2. REQ_PRIORITY with req2=1, others 0; req=1111 for 3 handshakes -> 0100 each time. Then req=1011 -> 0001,0010,1000,0001 (level-0 pointer untouched by the level-1 grants).
3. Lock: req=0011, en=1, last=0 -> grant 0001, busy=1 next cycle. Set req=0010 for 3 cycles with en=1, last=0 -> grant stays 0001, grant_id=0. Then en=1, last=1 -> IDLE, next grant 0010.
4. Pointer wrap: req=0101, single-beat handshakes -> 0001,0100,0001,0100. Then req=0011 after a grant of 0100 -> 0001 (wrap).
5. srst=1 asserted while LOCKED on requester 3 with en=1, last=0 -> busy=0, pointers 0 next cycle. With req=1111 -> grant 0001.
6. With AXICB_ARB_AGING_EN, AGE_MAX=4: req1 at priority 0, req0 at priority 3, both held, en=1, last=1 each cycle -> req0 wins 4 cycles, then grant 0010 once, then req0 resumes. Without the macro -> 0001 forever.
